imem_responder: RTL

- Memory-side responder for the instruction-cache refill interface.
- Accepts a level-held `mem_req` with `mem_addr` and returns one word on `mem_data`, qualified by a one-cycle `mem_ready` pulse, after a configurable latency with optional pseudo-random jitter.
- Backed by an internal word array that the testbench/loader fills through a load port.
- Sits between the icache and the simulated main memory in the NPC core.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_responder_lfsr4_jitter.sv | 24 ++
 rtl/imem_responder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// default error word and the jitter LFSR seed/taps.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // x^4 + x^3 + 1, Fibonacci form: feedback is bit3 ^ bit2, shifted in at bit0.
  localparam logic [3:0] LFSR_SEED = 4'b1001;
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/imem_responder_lfsr4_jitter.sv
// 4-bit LFSR that supplies 0..3 extra wait cycles to the responder.
module lfsr4_jitter
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [1:0] jitter
);

  logic [3:0] lfsr;

  // Free-running shift whenever enabled; seed restored by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign jitter = lfsr[1:0];

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the icache refill port. Accepts a level-held
// request, waits a programmable (optionally jittered) number of cycles and
// returns one word from an internal array with a one-cycle mem_ready strobe.
//
// state | meaning
// IDLE  | waiting for mem_req; accepts on the edge where mem_req=1
// WAIT  | counting down latency; mem_req drop aborts with no response
// RESP  | mem_ready/mem_data/mem_err valid for this single cycle
module imem_responder
  import imem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    LATENCY     = 3,
  parameter bit                    JITTER_EN   = 1'b0,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic                           mem_req,
  output logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           mem_ready,
  output logic                           mem_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]          ld_data,
  output logic                           busy,
  output logic [31:0]                    resp_count
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 4);
  localparam logic [ADDR_WIDTH-1:0] SPAN_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_load;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  resp_err_q;
  logic [1:0]            jitter;
  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic                  in_range;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  lfsr4_jitter u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en     (JITTER_EN),
    .jitter (jitter)
  );

  // Base-relative decode; subtraction wraps so addresses below BASE_ADDR land out of range.
  assign off      = addr_q - BASE_ADDR;
  assign idx      = off[IDX_W+1:2];
  assign in_range = (off < SPAN_BYTES);
  assign cnt_load = CNT_W'(LATENCY - 1) + (JITTER_EN ? CNT_W'(jitter) : CNT_W'(0));

  // Loader write port; array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; mem_req is not looked at in RESP (turnaround cycle).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req) state_nxt = WAIT;
      WAIT: begin
        if (!mem_req)      state_nxt = IDLE;
        else if (cnt == '0) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address capture, latency down-counter, response capture, counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      cnt         <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      resp_count  <= '0;
    end else begin
      if (state == IDLE && mem_req) begin
        addr_q <= mem_addr;
        cnt    <= cnt_load;
      end else if (state == WAIT && mem_req && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Captured from the pre-edge array, so a same-edge load is not visible here.
      if (state == WAIT && state_nxt == RESP) begin
        resp_data_q <= in_range ? mem[idx] : ERR_DATA;
        resp_err_q  <= ~in_range;
      end
      if (state == RESP && resp_count != 32'hFFFF_FFFF) begin
        resp_count <= resp_count + 32'd1;
      end
    end
  end

  // FSM outputs; data and error are forced to zero outside the RESP cycle.
  always_comb begin
    busy      = (state == WAIT) || (state == RESP);
    mem_ready = (state == RESP);
    mem_data  = '0;
    mem_err   = 1'b0;
    if (state == RESP) begin
      mem_data = resp_data_q;
      mem_err  = resp_err_q;
    end
  end

endmodule
